mult_div_hilo: RTL

Iterative signed multiply/divide unit for the multicycle MIPS datapath. It produces the HI and LO registers that feed the register write-data selector's `hi_data` and `lo_data` inputs. Each operation takes operands from the A/B register outputs and computes one bit per clock; `mult` takes 32 cycles and `div` takes 32 cycles. On completion it writes HI/LO and reports a one-cycle `done`. A divide-by-zero is flagged to the control unit's exception logic.

---
 rtl/mult_div_pkg.sv | 13 +
 rtl/div_restoring_step.sv | 24 ++
 rtl/mult_div_hilo.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared constants for the iterative HI/LO multiply/divide unit:
// FSM state encoding and iteration-counter sizing.
package mult_div_pkg;

    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep or restore.
module div_restoring_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic             q_bit,
    output logic [WIDTH-1:0] rem_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem_in < divisor <= 2**(WIDTH-1), so bit WIDTH of the trial is a clean borrow flag.
    always_comb begin
        shifted = {rem_in, dividend_bit};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[WIDTH];
        rem_out = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_hilo.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit that
// owns the MIPS HI and LO registers; one result bit per clock.
module mult_div_hilo
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [MD_CNT_W-1:0] LAST_ITER = MD_CNT_W'(MD_ITER - 1);

    logic [1:0]          state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic [2*WIDTH:0]    acc_q, acc_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic                div_zero_q, div_zero_d;

    logic [WIDTH-1:0]    p_hi, p_lo;
    logic [WIDTH:0]      booth_sum;
    logic [2*WIDTH:0]    booth_next;
    logic [2*WIDTH:0]    div_next;
    logic                step_q;
    logic [WIDTH-1:0]    step_rem;
    logic [WIDTH-1:0]    a_mag, b_mag;
    logic [WIDTH-1:0]    quo_raw, rem_raw;

    div_restoring_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (acc_q[2*WIDTH-1:WIDTH]),
        .dividend_bit (acc_q[WIDTH-1]),
        .divisor      (opnd_q),
        .q_bit        (step_q),
        .rem_out      (step_rem)
    );

    // Booth: acc = {P_hi, P_lo, q-1}. The sum keeps one guard bit so that the
    // arithmetic right shift is just "drop q-1" on {sum, P_lo}.
    always_comb begin
        p_hi = acc_q[2*WIDTH:WIDTH+1];
        p_lo = acc_q[WIDTH:1];
        case ({p_lo[0], acc_q[0]})
            2'b01:   booth_sum = {p_hi[WIDTH-1], p_hi} + {opnd_q[WIDTH-1], opnd_q};
            2'b10:   booth_sum = {p_hi[WIDTH-1], p_hi} - {opnd_q[WIDTH-1], opnd_q};
            default: booth_sum = {p_hi[WIDTH-1], p_hi};
        endcase
        booth_next = {booth_sum, p_lo};
    end

    // Divide: acc[2W-1:W] is the partial remainder, acc[W-1:0] shifts the
    // dividend out and the quotient in.
    always_comb begin
        div_next = {1'b0, step_rem, acc_q[WIDTH-2:0], step_q};
        quo_raw  = div_next[WIDTH-1:0];
        rem_raw  = div_next[2*WIDTH-1:WIDTH];
        a_mag    = a_data[WIDTH-1] ? (~a_data + 1'b1) : a_data;
        b_mag    = b_data[WIDTH-1] ? (~b_data + 1'b1) : b_data;
    end

    // NOTE: every signal assigned below gets a default first so the case arms
    // only override what changes; otherwise synthesis infers latches.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_mult) begin
                    opnd_d  = a_data;
                    acc_d   = {{WIDTH{1'b0}}, b_data, 1'b0};
                    cnt_d   = '0;
                    state_d = ST_MULT;
                end else if (start_div) begin
                    if (b_data != '0) begin
                        opnd_d    = b_mag;
                        acc_d     = {{(WIDTH+1){1'b0}}, a_mag};
                        neg_quo_d = a_data[WIDTH-1] ^ b_data[WIDTH-1];
                        neg_rem_d = a_data[WIDTH-1];
                        cnt_d     = '0;
                        state_d   = ST_DIV;
                    end else begin
                        div_zero_d = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_MULT: begin
                acc_d = booth_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    hi_d    = booth_next[2*WIDTH:WIDTH+1];
                    lo_d    = booth_next[WIDTH:1];
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    hi_d    = neg_rem_q ? (~rem_raw + 1'b1) : rem_raw;
                    lo_d    = neg_quo_q ? (~quo_raw + 1'b1) : quo_raw;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its peers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign busy     = (state_q == ST_MULT) || (state_q == ST_DIV);
    assign done     = (state_q == ST_DONE);
    assign div_zero = div_zero_q;

endmodule
